// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC sequencing controller: mode codes, FSM state
// encoding and the reserved-mode mapping used when a job is latched.
package mac_seq_ctrl_pkg;

    localparam logic [1:0] MAC_SINGLE    = 2'd0;
    localparam logic [1:0] MAC_DUAL      = 2'd1;
    localparam logic [1:0] MAC_QUAD      = 2'd2;
    localparam logic [1:0] MAC_MODE_RSVD = 2'd3;

    localparam int DRAIN_CNT_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // The reserved code would leave lanes in an undefined arrangement, so it runs as single.
    function automatic logic [1:0] legal_mode(input logic [1:0] mode);
        logic [1:0] result;
        case (mode)
            MAC_SINGLE, MAC_DUAL, MAC_QUAD: result = mode;
            default:                        result = MAC_SINGLE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mac_seq_down_counter.sv
// Loadable down counter with a zero flag; load wins over decrement, and the
// count holds at zero instead of wrapping.
module mac_seq_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the MAC lanes and combiner: clear, admit N beats, drain the
// pipeline, then hold the result. Optional stall counter: MAC_SEQ_STALL_CNT_EN.
module mac_seq_ctrl #(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int LEN_WIDTH      = 8,
    parameter int PIPE_LAT       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [MAC_CONF_WIDTH-1:0] cmd_cfg,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      op_valid,
    output logic                      op_ready,
    output logic                      mac_en,
    output logic                      mac_clr,
    output logic [MAC_CONF_WIDTH-1:0] mac_cfg,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    import mac_seq_ctrl_pkg::*;

    localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LOAD = DRAIN_CNT_WIDTH'(PIPE_LAT);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [MAC_CONF_WIDTH-1:0] mac_cfg_q;
    logic [MAC_CONF_WIDTH-1:0] mac_cfg_d;

    logic cmd_ready_q;
    logic op_ready_q;
    logic mac_clr_q;
    logic res_valid_q;
    logic busy_q;

    logic cmd_accept;
    logic beat_load;
    logic beat_dec;
    logic drain_load;
    logic drain_dec;
    logic beat_fire;

    logic [LEN_WIDTH-1:0]       beat_cnt;
    logic                       beat_zero;
    logic [DRAIN_CNT_WIDTH-1:0] drain_cnt;
    logic                       drain_zero;

    assign beat_fire = op_valid & op_ready_q;

    // Next-state logic; leaving CLR or RUN skips DRAIN entirely when there is no pipeline latency.
    always_comb begin
        state_d    = state_q;
        mac_cfg_d  = mac_cfg_q;
        cmd_accept = 1'b0;
        beat_load  = 1'b0;
        beat_dec   = 1'b0;
        drain_load = 1'b0;
        drain_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_accept     = 1'b1;
                    beat_load      = 1'b1;
                    mac_cfg_d      = cmd_cfg;
                    mac_cfg_d[1:0] = legal_mode(cmd_cfg[1:0]);
                    state_d        = ST_CLR;
                end
            end
            ST_CLR: begin
                if (!beat_zero) begin
                    state_d = ST_RUN;
                end else if (PIPE_LAT == 0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_load = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (beat_fire) begin
                    beat_dec = 1'b1;
                    if (beat_cnt == LEN_WIDTH'(1)) begin
                        if (PIPE_LAT == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            drain_load = 1'b1;
                            state_d    = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                drain_dec = 1'b1;
                if (drain_zero || (drain_cnt == DRAIN_CNT_WIDTH'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q without a decode delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mac_cfg_q   <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            mac_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mac_cfg_q   <= mac_cfg_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            op_ready_q  <= (state_d == ST_RUN);
            mac_clr_q   <= (state_d == ST_CLR);
            res_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    mac_seq_down_counter #(
        .WIDTH (LEN_WIDTH)
    ) u_beat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (beat_load),
        .load_val (cmd_len),
        .dec      (beat_dec),
        .count    (beat_cnt),
        .zero     (beat_zero)
    );

    mac_seq_down_counter #(
        .WIDTH (DRAIN_CNT_WIDTH)
    ) u_drain_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (DRAIN_LOAD),
        .dec      (drain_dec),
        .count    (drain_cnt),
        .zero     (drain_zero)
    );

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic        stall_cycle;

    // A stall is the operand side starving RUN or the consumer holding off DONE.
    assign stall_cycle = ((state_q == ST_RUN) && !op_valid) ||
                         ((state_q == ST_DONE) && !res_ready);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cmd_accept) begin
            stall_cnt_d = '0;
        end else if (stall_cycle && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign cmd_ready = cmd_ready_q;
    assign op_ready  = op_ready_q;
    assign mac_en    = beat_fire;
    assign mac_clr   = mac_clr_q;
    assign mac_cfg   = mac_cfg_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed jobs from the job timeline plus random jobs,
// each cycle checked against a job-level model of the clear/beat/drain/result timeline.
module tb_mac_seq_ctrl;

    localparam int CW       = 3;
    localparam int LW       = 8;
    localparam int PIPE_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_cfg;
    logic [LW-1:0] cmd_len;
    logic          op_valid;
    logic          op_ready;
    logic          mac_en;
    logic          mac_clr;
    logic [CW-1:0] mac_cfg;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    int            stallExp;
`endif

    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] expCfg;

    mac_seq_ctrl #(
        .MAC_CONF_WIDTH (CW),
        .LEN_WIDTH      (LW),
        .PIPE_LAT       (PIPE_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_cfg   (cmd_cfg),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_cfg   (mac_cfg),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef MAC_SEQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic eCmdReady, input logic eOpReady,
                            input logic eMacEn, input logic eMacClr, input logic eResValid,
                            input logic eBusy);
        checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(eCmdReady));
        checkOutput({tag, ".op_ready"},  32'(op_ready),  32'(eOpReady));
        checkOutput({tag, ".mac_en"},    32'(mac_en),    32'(eMacEn));
        checkOutput({tag, ".mac_clr"},   32'(mac_clr),   32'(eMacClr));
        checkOutput({tag, ".res_valid"}, 32'(res_valid), 32'(eResValid));
        checkOutput({tag, ".busy"},      32'(busy),      32'(eBusy));
        checkOutput({tag, ".mac_cfg"},   32'(mac_cfg),   32'(expCfg));
`ifdef MAC_SEQ_STALL_CNT_EN
        checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stallExp));
`endif
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One job: accept, clear, len beats (forced or random stalls), PIPE_LAT drain cycles, result held holdDone cycles.
    task automatic applyStimulus(input int len, input logic [CW-1:0] cfg, input logic [31:0] stallMask,
                                 input int stallPct, input int holdDone);
        int   beats;
        int   runIdx;
        int   consec;
        logic ov;

        cmd_valid = 1'b1;
        cmd_cfg   = cfg;
        cmd_len   = LW'(len);
        op_valid  = 1'($urandom_range(0, 1));
        res_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkAll("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        expCfg = cfg;
        if (cfg[1:0] == 2'b11) expCfg[1:0] = 2'b00;
`ifdef MAC_SEQ_STALL_CNT_EN
        stallExp = 0;
`endif

        cmd_valid = 1'($urandom_range(0, 1));
        cmd_cfg   = CW'($urandom);
        cmd_len   = LW'($urandom);
        op_valid  = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkAll("clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        nextCycle();

        beats  = 0;
        runIdx = 0;
        consec = 0;
        while (beats < len) begin
            if (runIdx < 32 && stallMask[runIdx]) ov = 1'b0;
            else if (consec < 3 && $urandom_range(0, 99) < stallPct) ov = 1'b0;
            else ov = 1'b1;
            op_valid  = ov;
            cmd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkAll("run", 1'b0, 1'b1, ov, 1'b0, 1'b0, 1'b1);
            nextCycle();
            if (ov) begin
                beats++;
                consec = 0;
            end else begin
                consec++;
`ifdef MAC_SEQ_STALL_CNT_EN
                stallExp++;
`endif
            end
            runIdx++;
        end

        for (int d = 0; d < PIPE_LAT; d++) begin
            op_valid  = 1'($urandom_range(0, 1));
            cmd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkAll("drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            nextCycle();
        end

        for (int h = 0; h <= holdDone; h++) begin
            res_ready = (h >= holdDone);
            cmd_valid = (h < holdDone) ? 1'b1 : 1'($urandom_range(0, 1));
            op_valid  = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkAll("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            nextCycle();
`ifdef MAC_SEQ_STALL_CNT_EN
            if (!res_ready) stallExp++;
`endif
        end

        cmd_valid = 1'b0;
        res_ready = 1'($urandom_range(0, 1));
        op_valid  = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkAll("post", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_cfg   = '0;
        cmd_len   = '0;
        op_valid  = 1'b1;
        res_ready = 1'b0;
        expCfg    = '0;
`ifdef MAC_SEQ_STALL_CNT_EN
        stallExp  = 0;
`endif
        @(negedge clk);
        checkAll("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        nextCycle();

        applyStimulus(4, 3'b010, 32'h0, 0, 0);
        applyStimulus(3, 3'b000, 32'h2, 0, 0);
        applyStimulus(0, 3'b001, 32'h0, 0, 0);
        applyStimulus(2, 3'b111, 32'h0, 0, 0);
        applyStimulus(2, 3'b110, 32'h0, 0, 5);

        // Abort a 6-beat job after two beats; reset must act without waiting for a clock edge.
        cmd_valid = 1'b1;
        cmd_cfg   = 3'b110;
        cmd_len   = LW'(6);
        op_valid  = 1'b1;
        res_ready = 1'b1;
        nextCycle();
        cmd_valid = 1'b0;
        expCfg    = 3'b110;
        nextCycle();
        nextCycle();
        nextCycle();
        #2;
        rst = 1'b0;
        #1;
        expCfg = '0;
`ifdef MAC_SEQ_STALL_CNT_EN
        stallExp = 0;
`endif
        checkAll("abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        nextCycle();
        applyStimulus(6, 3'b001, 32'h0, 0, 0);

        for (int j = 0; j < 25; j++) begin
            applyStimulus($urandom_range(0, 12), CW'($urandom), 32'h0, 30, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the MAC array and its output combiner. It accepts one dot-product job at a time (mode, beat count) and clears the accumulator. It then admits exactly that many operand beats into the datapath, waits out the datapath pipeline latency, and presents a result-valid handshake to the consumer. It sits between the command/operand streams and the MAC lanes plus combiner, and owns their `en`/`cfg`/clear controls.

## Interface
- `MAC_CONF_WIDTH`, 3: width of mode/config word; bits [1:0] select single/dual/quad.
- `LEN_WIDTH`, 8: width of the beat-count field.
- `PIPE_LAT`, 2: cycles from a `mac_en` beat to its contribution being visible on combiner outputs; legal range 0..15.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  job command offered.
- `cmd_ready`  out  1  controller can accept a job.
- `cmd_cfg`  in  MAC_CONF_WIDTH  job mode.
- `cmd_len`  in  LEN_WIDTH  operand beats in job (0 legal).
- `op_valid`  in  1  operand beat present on the datapath inputs.
- `op_ready`  out  1  datapath consumes the beat this cycle.
- `mac_en`  out  1  accumulate enable to MAC lanes.
- `mac_clr`  out  1  accumulator clear pulse.
- `mac_cfg`  out  MAC_CONF_WIDTH  latched mode to lanes and combiner.
- `res_valid`  out  1  combiner outputs hold the job result.
- `res_ready`  in  1  consumer takes the result.
- `busy`  out  1  state != IDLE.
- `stall_cnt`  out  16  stall-cycle count (only with `MAC_SEQ_STALL_CNT_EN`).

## Operation
- States: IDLE, CLR, RUN, DRAIN, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_cfg` into `mac_cfg` and `cmd_len` into the beat counter, then go to CLR.
  - Reserved mode (`cmd_cfg[1:0]`==2'b11) is latched as `MAC_SINGLE`; upper cfg bits are kept.
- **CLR**
  - Lasts one cycle with `mac_clr`=1 and `op_ready`=0.
  - Go to RUN if len!=0, else to DRAIN.
- **RUN**
  - `op_ready`=1.
  - `mac_en` = `op_valid & op_ready`, combinational; each such beat decrements the counter.
  - The beat that takes the counter to 0 moves the FSM to DRAIN and loads the drain counter with `PIPE_LAT`.
  - `op_valid`=0 holds state; there is no timeout.
- **DRAIN**
  - Decrement the drain counter each cycle; go to DONE when it is 0.
  - `PIPE_LAT`=0 makes DRAIN pass straight through to DONE with zero dwell; the FSM still enters DONE the cycle after the last beat.
- **DONE**
  - `res_valid`=1 until `res_ready`; on the handshake cycle go to IDLE.
  - `mac_cfg` stays stable through DONE so the combiner outputs remain valid.
- `mac_en` and `op_ready` are 0 outside RUN; `cmd_ready` is 0 outside IDLE, so jobs never overlap.
- `cmd_valid` in a non-IDLE state is ignored (not latched).
- Reset mid-job aborts the job immediately: all state is discarded and no result is produced.

## Timing
- Reset values:
  - state IDLE, `cmd_ready`=1, `op_ready`=0, `mac_en`=0, `mac_clr`=0.
  - `mac_cfg`=`MAC_SINGLE`, `res_valid`=0, `busy`=0, `stall_cnt`=0.
- `mac_clr`, `mac_cfg`, `res_valid`, `busy` and `cmd_ready` are registered-state decodes; `mac_en` is combinational from `op_valid`.
- Latency, job of length N accepted in cycle 0 with no stalls:
  - CLR in cycle 1.
  - Beats in cycles 2..N+1.
  - DRAIN in cycles N+2..N+1+`PIPE_LAT`.
  - `res_valid` first high in cycle N+2+`PIPE_LAT`.
  - N=0 follows the same formula.
- Every operand stall cycle adds one cycle to that latency.
- Back-to-back jobs: the next command is accepted no earlier than the cycle after the result handshake.

## Configuration
- `MAC_SEQ_STALL_CNT_EN` defined:
  - `stall_cnt` counts cycles in RUN with `op_valid`=0 plus cycles in DONE with `res_ready`=0.
  - It clears on command accept and saturates at 16'hFFFF.
- `MAC_SEQ_STALL_CNT_EN` undefined: the `stall_cnt` port and its logic are absent; all other behaviour is identical.

## Structure
- Mode codes `MAC_SINGLE`=2'd0, `MAC_DUAL`=2'd1 and `MAC_QUAD`=2'd2 stay in `mac_const.vh`.
- FSM state encodings and the reserved-mode code are added to `mac_const.vh`.
- One sub-module, `mac_seq_down_counter`:
  - loadable, decrementing, with a zero flag;
  - instantiated twice: beat counter (`LEN_WIDTH`) and drain counter (4 bits).

## Test plan
- Job cfg=`MAC_QUAD`, len=4, `op_valid` held 1, `res_ready`=1, `PIPE_LAT`=2, accepted in cycle 0:
  - `mac_clr` high in cycle 1 only; `mac_en` high in cycles 2-5; `res_valid` high in cycle 8 only; `busy` low in cycle 9.
- len=3 with `op_valid` low in the second RUN cycle: exactly 3 `mac_en` pulses; `res_valid` in cycle 8; `stall_cnt`=1.
- len=0, cfg=`MAC_DUAL`: `mac_clr` in cycle 1; no `mac_en`; `res_valid` in cycle 4.
- cfg[1:0]=2'b11: `mac_cfg[1:0]`=`MAC_SINGLE` from cycle 1.
- Hold `res_ready`=0 for 5 cycles in DONE: `res_valid` stays 1; a second `cmd_valid` meanwhile is not accepted; `stall_cnt` reads 5.
- Assert reset during RUN after 2 of 6 beats: all outputs return to reset values asynchronously; the next job runs its full length with a fresh `mac_clr`.
